// File: rtl/err_sq_meas_ctrl_pkg.sv
// err_sq_meas_ctrl_pkg: state encodings shared by the measurement-window sequencer
package err_sq_meas_ctrl_pkg;
  localparam logic [1:0] EMC_IDLE   = 2'd0;
  localparam logic [1:0] EMC_SETTLE = 2'd1;
  localparam logic [1:0] EMC_ACCUM  = 2'd2;
  localparam logic [1:0] EMC_LATCH  = 2'd3;
endpackage

// File: rtl/err_sq_meas_ctrl_sym_cnt.sv
// err_sq_meas_ctrl_sym_cnt: clk_en-qualified symbol counter with terminal-count compare
module err_sq_meas_ctrl_sym_cnt #(
  parameter int W = 23
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] load,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset || clr) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  assign tc = en && (cnt == load);
endmodule

// File: rtl/err_sq_meas_ctrl.sv
// err_sq_meas_ctrl: sequences clear/hold of err_sq_gen so each result sums exactly 2^WIN_LOG2 symbols
module err_sq_meas_ctrl
  import err_sq_meas_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 22,
  parameter int SETTLE   = 64,
  parameter int WCNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              abort,
  input  logic              result_ack,
  output logic              acc_clear,
  output logic              acc_hold,
  output logic              busy,
  output logic              result_valid,
  output logic              overrun,
  output logic [WCNT_W-1:0] win_count
);
  localparam int CW = WIN_LOG2 + 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CW-1:0] WIN_LD = {1'b0, {WIN_LOG2{1'b1}}};
  logic [1:0] state;
  logic cont, stop_pend, tc, cap, start_ok;
  assign acc_hold  = state == EMC_LATCH;
  // clear in LATCH only alongside clk_en, otherwise the sum vanishes before capture
  assign acc_clear = (state == EMC_LATCH) ? clk_en : (state != EMC_ACCUM);
  assign busy      = state != EMC_IDLE;
  assign cap       = (state == EMC_LATCH) && clk_en && !abort;
  assign start_ok  = (state == EMC_IDLE) && start && !abort;
  err_sq_meas_ctrl_sym_cnt #(.W(CW)) u_sym_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (clk_en && (state == EMC_SETTLE || state == EMC_ACCUM)),
    .clr  (state == EMC_IDLE || state == EMC_LATCH || tc),
    .load ((state == EMC_SETTLE) ? SETTLE_LD : WIN_LD),
    .tc   (tc)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      state        <= EMC_IDLE;
      cont         <= 1'b0;
      stop_pend    <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      win_count    <= '0;
    end else begin
      if (abort) state <= EMC_IDLE;
      else case (state)
        EMC_IDLE: if (start) begin
          state     <= (SETTLE > 0) ? EMC_SETTLE : EMC_ACCUM;
          cont      <= continuous;
          stop_pend <= 1'b0;
          win_count <= '0;
        end
        EMC_SETTLE: state <= stop ? EMC_IDLE : tc ? EMC_ACCUM : EMC_SETTLE;
        EMC_ACCUM: begin
          if (stop) stop_pend <= 1'b1;
          if (tc) state <= EMC_LATCH;
        end
        default: begin
          if (stop) stop_pend <= 1'b1;
          if (clk_en) begin
            win_count <= win_count + WCNT_W'(1);
            state     <= (cont && !stop_pend && !stop) ? EMC_ACCUM : EMC_IDLE;
          end
        end
      endcase
      result_valid <= abort ? result_valid : cap | (result_valid & ~result_ack);
      overrun      <= start_ok ? 1'b0 : overrun | (cap & result_valid & ~result_ack);
    end
endmodule

// File: tb/tb_err_sq_meas_ctrl.sv
// tb_err_sq_meas_ctrl: directed bench with a small err=1 accumulator model standing in for err_sq_gen
module tb_err_sq_meas_ctrl;
  logic clk, reset, clk_en, start, continuous, stop, abort, result_ack;
  logic acc_clear, acc_hold, busy, result_valid, overrun;
  logic [15:0] win_count;
  int checks = 0, errors = 0;
  int sym_ctr = 0, acc = 0, cap_val = 0;
  logic en_run = 1'b1, ack_auto = 1'b0;

  err_sq_meas_ctrl #(.WIN_LOG2(4), .SETTLE(3), .WCNT_W(16)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .continuous(continuous),
    .stop(stop), .abort(abort), .result_ack(result_ack), .acc_clear(acc_clear),
    .acc_hold(acc_hold), .busy(busy), .result_valid(result_valid), .overrun(overrun),
    .win_count(win_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    clk_en = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      clk_en = en_run ? ~clk_en : 1'b0;
    end
  end

  always @(posedge clk) if (clk_en) sym_ctr <= sym_ctr + 1;

  // err_sq_gen stand-in: err=1 adds 1 per symbol, clear wins and captures while held
  always @(posedge clk)
    if (!reset) begin
      acc <= 0;
      cap_val <= 0;
    end else if (clk_en) begin
      if (acc_clear) begin
        if (acc_hold) cap_val <= acc;
        acc <= 0;
      end else if (!acc_hold) acc <= acc + 1;
    end

  task automatic drive(input logic s, input logic sp, input logic ab, input logic c);
    @(posedge clk); #2;
    start = s; stop = sp; abort = ab; continuous = c;
    @(posedge clk); #2;
    start = 0; stop = 0; abort = 0;
  endtask

  task automatic ack_once();
    @(posedge clk); #2 result_ack = 1;
    @(posedge clk); #2 result_ack = 0;
  endtask

  task automatic wait_cap();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      result_ack = ack_auto && result_valid;
      if (acc_hold && acc_clear) return;
    end
    checks++; errors++;
    $display("FAIL wait_cap: no capture within 400 cycles");
  endtask

  task automatic wait_accum();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy && !acc_clear && !acc_hold) return;
    end
    checks++; errors++;
    $display("FAIL wait_accum: ACCUM not reached within 100 cycles");
  endtask

  task automatic test_reset();
    reset = 0; start = 0; continuous = 0; stop = 0; abort = 0; result_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, result_valid, overrun, acc_clear, acc_hold, win_count} !== {5'b00010, 16'd0}) begin
      errors++;
      $display("FAIL reset: got %b/%0d exp 00010/0", {busy, result_valid, overrun, acc_clear, acc_hold}, win_count);
    end
    #2 reset = 1;
  endtask

  task automatic test_single();
    int s0;
    drive(1, 0, 0, 0);
    s0 = sym_ctr;
    wait_cap();
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL single_pre_rv: got %b exp 0", result_valid); end
    @(negedge clk);
    checks++;
    if (sym_ctr - s0 !== 20) begin errors++; $display("FAIL single_syms: got %0d exp 20", sym_ctr - s0); end
    checks++;
    if ({result_valid, busy, overrun} !== 3'b100 || win_count !== 16'd1) begin
      errors++; $display("FAIL single_done: got rv/busy/ov=%b wc=%0d exp 100 wc=1", {result_valid, busy, overrun}, win_count);
    end
    checks++;
    if (cap_val !== 16) begin errors++; $display("FAIL single_sum: got %0d exp 16", cap_val); end
    ack_once();
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got %b exp 0", result_valid); end
  endtask

  task automatic test_continuous_ack();
    int s;
    ack_auto = 1;
    drive(1, 0, 0, 1);
    s = sym_ctr;
    for (int k = 1; k <= 3; k++) begin
      wait_cap();
      @(negedge clk);
      checks++;
      if (sym_ctr - s !== ((k == 1) ? 20 : 17)) begin
        errors++; $display("FAIL cont_syms%0d: got %0d exp %0d", k, sym_ctr - s, (k == 1) ? 20 : 17);
      end
      checks++;
      if (win_count !== 16'(k) || overrun !== 1'b0 || cap_val !== 16) begin
        errors++; $display("FAIL cont_win%0d: got wc=%0d ov=%b sum=%0d exp wc=%0d ov=0 sum=16", k, win_count, overrun, cap_val, k);
      end
      s = sym_ctr;
    end
    ack_auto = 0; result_ack = 0;
    drive(0, 0, 1, 0);
    @(negedge clk);
    checks++;
    if ({busy, result_valid, win_count} !== {2'b01, 16'd3}) begin
      errors++; $display("FAIL cont_abort: got busy=%b rv=%b wc=%0d exp busy=0 rv=1 wc=3", busy, result_valid, win_count);
    end
    ack_once();
  endtask

  task automatic test_overrun();
    drive(1, 0, 0, 1);
    wait_cap();
    @(negedge clk);
    wait_cap();
    @(negedge clk);
    checks++;
    if ({result_valid, overrun, win_count} !== {2'b11, 16'd2}) begin
      errors++; $display("FAIL overrun_set: got rv=%b ov=%b wc=%0d exp 1 1 2", result_valid, overrun, win_count);
    end
    drive(0, 0, 1, 0);
    @(negedge clk);
    checks++;
    if ({busy, overrun} !== 2'b01) begin errors++; $display("FAIL overrun_sticky: got busy/ov=%b exp 01", {busy, overrun}); end
    drive(1, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({busy, overrun, win_count} !== {2'b10, 16'd0}) begin
      errors++; $display("FAIL overrun_clear: got busy=%b ov=%b wc=%0d exp 1 0 0", busy, overrun, win_count);
    end
    drive(0, 0, 1, 0);
    ack_once();
  endtask

  task automatic test_cap_ack();
    drive(1, 0, 0, 1);
    wait_cap();
    @(negedge clk);
    wait_cap();
    result_ack = 1;
    @(negedge clk);
    result_ack = 0;
    checks++;
    if ({result_valid, overrun} !== 2'b10) begin
      errors++; $display("FAIL cap_ack: got rv/ov=%b exp 10", {result_valid, overrun});
    end
    drive(0, 0, 1, 0);
    ack_once();
  endtask

  task automatic test_stop();
    int s1;
    logic ok;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    @(negedge clk);
    checks++;
    if ({busy, result_valid} !== 2'b00) begin errors++; $display("FAIL stop_settle: got busy/rv=%b exp 00", {busy, result_valid}); end
    ack_auto = 1;
    drive(1, 0, 0, 1);
    wait_cap();
    @(negedge clk);
    s1 = sym_ctr;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      result_ack = ack_auto && result_valid;
      ok = (sym_ctr - s1 >= 8);
    end
    drive(0, 1, 0, 0);
    wait_cap();
    @(negedge clk);
    ack_auto = 0; result_ack = 0;
    checks++;
    if (sym_ctr - s1 !== 17) begin errors++; $display("FAIL stop_syms: got %0d exp 17", sym_ctr - s1); end
    checks++;
    if ({busy, result_valid, win_count} !== {2'b01, 16'd2}) begin
      errors++; $display("FAIL stop_done: got busy=%b rv=%b wc=%0d exp 0 1 2", busy, result_valid, win_count);
    end
    repeat (60) @(negedge clk);
    checks++;
    if ({busy, win_count} !== {1'b0, 16'd2}) begin errors++; $display("FAIL stop_idle: got busy=%b wc=%0d exp 0 2", busy, win_count); end
    ack_once();
  endtask

  task automatic test_abort();
    drive(1, 0, 0, 0);
    wait_accum();
    repeat (4) @(negedge clk);
    drive(0, 0, 1, 0);
    @(negedge clk);
    checks++;
    if ({busy, acc_clear, acc_hold} !== 3'b010) begin
      errors++; $display("FAIL abort_idle: got busy/clr/hold=%b exp 010", {busy, acc_clear, acc_hold});
    end
    repeat (60) @(negedge clk);
    checks++;
    if ({result_valid, win_count} !== {1'b0, 16'd0}) begin
      errors++; $display("FAIL abort_noresult: got rv=%b wc=%0d exp 0 0", result_valid, win_count);
    end
  endtask

  task automatic test_latch_stall();
    logic seen = 0;
    logic bad = 0;
    drive(1, 0, 0, 0);
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = acc_hold;
    end
    en_run = 0;
    bad = !seen || acc_clear;
    repeat (5) begin
      @(negedge clk);
      bad = bad || acc_clear || !acc_hold;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL latch_stall: got clr=%b hold=%b exp clr=0 hold=1", acc_clear, acc_hold); end
    en_run = 1;
    wait_cap();
    @(negedge clk);
    checks++;
    if ({result_valid, win_count} !== {1'b1, 16'd1} || cap_val !== 16) begin
      errors++; $display("FAIL latch_resume: got rv=%b wc=%0d sum=%0d exp 1 1 16", result_valid, win_count, cap_val);
    end
    ack_once();
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 0, 1);
    wait_accum();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 reset = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, result_valid, overrun, acc_clear, acc_hold, win_count} !== {5'b00010, 16'd0}) begin
      errors++; $display("FAIL reset_mid: got %b/%0d exp 00010/0", {busy, result_valid, overrun, acc_clear, acc_hold}, win_count);
    end
    #2 reset = 1;
  endtask

  task automatic test_start_busy();
    int s0;
    drive(1, 0, 0, 0);
    s0 = sym_ctr;
    wait_accum();
    drive(1, 0, 0, 1);
    wait_cap();
    @(negedge clk);
    checks++;
    if (sym_ctr - s0 !== 20 || win_count !== 16'd1) begin
      errors++; $display("FAIL start_busy: got syms=%0d wc=%0d exp 20 1", sym_ctr - s0, win_count);
    end
    repeat (50) @(negedge clk);
    checks++;
    if ({busy, win_count} !== {1'b0, 16'd1}) begin errors++; $display("FAIL start_busy_mode: got busy=%b wc=%0d exp 0 1", busy, win_count); end
    ack_once();
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous_ack();
    test_overrun();
    test_cap_ack();
    test_stop();
    test_abort();
    test_latch_stall();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
